muldiv_sequencer: RTL and testbench

//  Multi-cycle sequencer for the RV32M execute path. Accepts one MUL*/DIV*/REM* op from EX and

---
 rtl/muldiv_pkg.sv | 66 ++++++
 rtl/muldiv_iter_datapath.sv | 126 ++++++++++++
 rtl/muldiv_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types, widths and decode helpers for the RV32M
// multi-cycle multiply/divide sequencer and its iterative datapath.
//   XLEN      operand/result width; also the iteration count
//   CNT_W     width of the iteration counter
//   md_op_e   funct3 encoding of the eight M-extension ops
//   state_e   sequencer FSM states
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  XLEN_ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  XLEN_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  XLEN_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  // rs1 is treated as two's complement for these ops.
  function automatic logic is_signed_a(input md_op_e op);
    case (op)
      MD_MULH, MD_MULHSU, MD_DIV, MD_REM: is_signed_a = 1'b1;
      default:                            is_signed_a = 1'b0;
    endcase
  endfunction

  // rs2 is treated as two's complement for these ops (MULHSU excluded).
  function automatic logic is_signed_b(input md_op_e op);
    case (op)
      MD_MULH, MD_DIV, MD_REM: is_signed_b = 1'b1;
      default:                 is_signed_b = 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input md_op_e op);
    case (op)
      MD_DIV, MD_DIVU, MD_REM, MD_REMU: is_div_op = 1'b1;
      default:                          is_div_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_rem_op(input md_op_e op);
    case (op)
      MD_REM, MD_REMU: is_rem_op = 1'b1;
      default:         is_rem_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_iter_datapath.sv
// muldiv_iter_datapath: shared register set for the iterative multiplier and
// restoring divider, plus the sign fix-up and result select.
//   clk, rst        clock, asynchronous active-high reset
//   load_i          load magnitudes, clear accumulator
//   step_i          perform one shift-add or trial-subtract step
//   fix_i           capture the final (or special-case) result
//   fix_special_i   with fix_i: take special_val_i instead of the computed value
//   op_i            latched operation
//   sign_a_i/b_i    latched operand signs (already 0 for unsigned operands)
//   mag_a_i/b_i     operand magnitudes
//   special_val_i   precomputed div-by-zero / overflow result
//   result_o        registered result, holds until the next fix_i
module muldiv_iter_datapath
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            fix_i,
  input  logic            fix_special_i,
  input  md_op_e          op_i,
  input  logic            sign_a_i,
  input  logic            sign_b_i,
  input  logic [XLEN-1:0] mag_a_i,
  input  logic [XLEN-1:0] mag_b_i,
  input  logic [XLEN-1:0] special_val_i,
  output logic [XLEN-1:0] result_o
);

  // hi: upper product half / partial remainder
  // lo: multiplier being shifted out / dividend shifted out, quotient shifted in
  // dvs: multiplicand / divisor
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic              is_div_s;
  logic [XLEN:0]     mul_sum_s;
  logic [XLEN:0]     div_shift_s;
  logic              div_ge_s;
  logic [XLEN-1:0]   div_sub_s;
  logic [2*XLEN-1:0] prod_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s;
  logic [XLEN-1:0]   rem_fix_s;
  logic [XLEN-1:0]   fixed_s;

  assign is_div_s    = is_div_op(op_i);
  assign mul_sum_s   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? dvs_q : XLEN_ZERO)};
  assign div_shift_s = {hi_q, lo_q[XLEN-1]};
  // Only the low XLEN bits of the difference are kept: when the trial
  // succeeds the true remainder is below the divisor and fits in XLEN bits.
  assign div_ge_s    = (div_shift_s >= {1'b0, dvs_q});
  assign div_sub_s   = div_shift_s[XLEN-1:0] - dvs_q;

  assign prod_s      = {hi_q, lo_q};
  assign prod_fix_s  = (sign_a_i ^ sign_b_i) ? -prod_s : prod_s;
  assign quo_fix_s   = (sign_a_i ^ sign_b_i) ? -lo_q : lo_q;
  assign rem_fix_s   = sign_a_i ? -hi_q : hi_q;   // remainder follows dividend

  // Result select after sign fix-up.
  always_comb begin
    fixed_s = XLEN_ZERO;
    case (op_i)
      MD_MUL:                       fixed_s = prod_fix_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fixed_s = prod_fix_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fixed_s = quo_fix_s;
      MD_REM, MD_REMU:              fixed_s = rem_fix_s;
      default:                      fixed_s = XLEN_ZERO;
    endcase
  end

  // Next values for the working registers and the result register.
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    dvs_d = dvs_q;
    res_d = res_q;
    if (load_i) begin
      hi_d = XLEN_ZERO;
      if (is_div_s) begin
        lo_d  = mag_a_i;
        dvs_d = mag_b_i;
      end else begin
        lo_d  = mag_b_i;
        dvs_d = mag_a_i;
      end
    end else if (step_i) begin
      if (is_div_s) begin
        hi_d = div_ge_s ? div_sub_s : div_shift_s[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], div_ge_s};
      end else begin
        hi_d = mul_sum_s[XLEN:1];
        lo_d = {mul_sum_s[0], lo_q[XLEN-1:1]};
      end
    end else begin
      hi_d = hi_q;
      lo_d = lo_q;
    end
    if (fix_i) begin
      res_d = fix_special_i ? special_val_i : fixed_s;
    end else begin
      res_d = res_q;
    end
  end

  // Datapath register update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q  <= XLEN_ZERO;
      lo_q  <= XLEN_ZERO;
      dvs_q <= XLEN_ZERO;
      res_q <= XLEN_ZERO;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      dvs_q <= dvs_d;
      res_q <= res_d;
    end
  end

  assign result_o = res_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M sequencer. Accepts one MUL/DIV/REM op
// from EX, stalls the pipeline while the iterative datapath runs, resolves
// div-by-zero and signed overflow without iterating, and returns the result.
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start_i    M-op valid in EX (level, held while stalled)
//   flush_i    EX flush; aborts the op in flight, wins over start_i
//   funct3_i   operation select (md_op_e encoding)
//   op_a_i     rs1 value
//   op_b_i     rs2 value
//   stall_o    hold IF/ID/EX (combinational)
//   busy_o     registered, high whenever the FSM is not in IDLE
//   done_o     one-cycle pulse, result_o valid
//   result_o   result, holds until the next done_o
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_e           op_q, op_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             special_q, special_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  md_op_e           new_op_s;
  logic [XLEN-1:0]  mag_a_s;
  logic [XLEN-1:0]  mag_b_s;
  logic             div_zero_s;
  logic             div_ovf_s;
  logic             special_s;
  logic [XLEN-1:0]  special_val_s;
  logic             load_s;
  logic             step_s;
  logic             fix_s;
  logic             fix_special_s;

  assign new_op_s = md_op_e'(funct3_i);
  assign mag_a_s  = sign_a_q ? -a_q : a_q;
  assign mag_b_s  = sign_b_q ? -b_q : b_q;

  // Special divides are detected on the latched operands, which stay stable
  // for the whole op, so the same value serves LOAD and (if iterating) FIX.
  assign div_zero_s = is_div_op(op_q) && (b_q == XLEN_ZERO);
  assign div_ovf_s  = is_div_op(op_q) && is_signed_a(op_q) &&
                      (a_q == XLEN_MIN) && (b_q == XLEN_ONES);
  assign special_s  = div_zero_s || div_ovf_s;

  // RISC-V defined results for divide by zero and signed overflow.
  always_comb begin
    special_val_s = XLEN_ZERO;
    if (div_zero_s) begin
      special_val_s = is_rem_op(op_q) ? a_q : XLEN_ONES;
    end else if (div_ovf_s) begin
      special_val_s = is_rem_op(op_q) ? XLEN_ZERO : XLEN_MIN;
    end else begin
      special_val_s = XLEN_ZERO;
    end
  end

  // Datapath strobes; a flush suppresses every strobe so result_o is untouched.
  assign load_s        = (state_q == LOAD) && !flush_i;
  assign step_s        = (state_q == ITER) && !flush_i;
  assign fix_s         = ((state_q == FIX) && !flush_i) ||
                         (load_s && special_s && EARLY_OUT);
  assign fix_special_s = (state_q == LOAD) ? 1'b1 : special_q;

  assign stall_o = ((state_q == IDLE) && start_i && !flush_i) ||
                   (state_q inside {LOAD, ITER, FIX});

  // FSM next-state, counter and operand latch logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    special_d = special_q;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          state_d  = LOAD;
          op_d     = new_op_s;
          a_d      = op_a_i;
          b_d      = op_b_i;
          sign_a_d = op_a_i[XLEN-1] & is_signed_a(new_op_s);
          sign_b_d = op_b_i[XLEN-1] & is_signed_b(new_op_s);
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        cnt_d     = {CNT_W{1'b0}};
        special_d = special_s;
        if (flush_i) begin
          state_d = IDLE;
        end else if (special_s && EARLY_OUT) begin
          state_d = DONE;
        end else begin
          state_d = ITER;
        end
      end
      ITER: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == CNT_LAST) begin
            state_d = FIX;
          end else begin
            state_d = ITER;
          end
        end
      end
      FIX: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      op_q      <= MD_MUL;
      a_q       <= XLEN_ZERO;
      b_q       <= XLEN_ZERO;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      special_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      special_q <= special_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

  muldiv_iter_datapath u_datapath (
    .clk           (clk),
    .rst           (rst),
    .load_i        (load_s),
    .step_i        (step_s),
    .fix_i         (fix_s),
    .fix_special_i (fix_special_s),
    .op_i          (op_q),
    .sign_a_i      (sign_a_q),
    .sign_b_i      (sign_b_q),
    .mag_a_i       (mag_a_s),
    .mag_b_i       (mag_b_s),
    .special_val_i (special_val_s),
    .result_o      (result_o)
  );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors with hand-computed results, latency,
// stall/busy/done behaviour, flush abort, async reset mid-op, back-to-back ops.
module tb_muldiv_sequencer;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam int LAT_NORM = 35;
  localparam int LAT_SPEC = 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int n_checks;
  int n_errors;

  muldiv_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .flush_i  (flush),
    .funct3_i (funct3),
    .op_a_i   (op_a),
    .op_b_i   (op_b),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op (optionally after one idle-settling edge), hold start while
  // stalled, and check latency, result and handshake signals.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input bit pre_wait);
    int lat;
    int stall_bad;
    bit seen;
    if (pre_wait) begin
      @(posedge clk); #1;
      check_val({tag, "_prev_pulse"}, 32'(done_o), 32'd0);
    end
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    flush  = 1'b0;
    seen   = 1'b0;
    lat    = 0;
    stall_bad = 0;
    #1;
    if (!stall_o) stall_bad++;
    for (int j = 1; j <= 60 && !seen; j++) begin
      @(posedge clk); #1;
      if (done_o) begin
        seen = 1'b1;
        lat  = j;
      end else if (!stall_o) begin
        stall_bad++;
      end
    end
    start = 1'b0;
    check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_result"}, result_o, exp_res);
    check_val({tag, "_stall_held"}, 32'(stall_bad), 32'd0);
    check_val({tag, "_stall_in_done"}, 32'(stall_o), 32'd0);
    check_val({tag, "_busy_in_done"}, 32'(busy_o), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = 3'b000;
    op_a   = 32'd0;
    op_b   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", 32'(busy_o), 32'd0);
    check_val("rst_done", 32'(done_o), 32'd0);
    check_val("rst_stall", 32'(stall_o), 32'd0);
    check_val("rst_result", result_o, 32'd0);
    rst = 1'b0;

    run_op("mul_neg",   F_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_NORM, 1'b1);
    run_op("mulh_min",  F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_NORM, 1'b1);
    run_op("mulhu_min", F_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_NORM, 1'b1);
    run_op("mulhsu",    F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_NORM, 1'b1);
    run_op("div_neg",   F_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT_NORM, 1'b1);
    run_op("rem_neg",   F_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT_NORM, 1'b1);
    run_op("divu",      F_DIVU,   32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, LAT_NORM, 1'b1);
    run_op("div_by0",   F_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, LAT_SPEC, 1'b1);
    run_op("remu_by0",  F_REMU,   32'd5,         32'd0,         32'd5,         LAT_SPEC, 1'b1);

    // Flush at ITER step 10: previous result (5) must survive.
    @(posedge clk); #1;
    funct3 = F_MUL;
    op_a   = 32'd3;
    op_b   = 32'd5;
    start  = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk); #1;
    end
    check_val("pre_flush_busy", 32'(busy_o), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    check_val("flush_busy", 32'(busy_o), 32'd0);
    check_val("flush_done", 32'(done_o), 32'd0);
    check_val("flush_stall", 32'(stall_o), 32'd0);
    check_val("flush_result", result_o, 32'd5);
    @(posedge clk); #1;
    check_val("flush_prio_busy", 32'(busy_o), 32'd0);
    check_val("flush_prio_done", 32'(done_o), 32'd0);
    flush = 1'b0;
    run_op("mul_after_flush", F_MUL, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, LAT_NORM, 1'b0);

    run_op("div_ovf",   F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPEC, 1'b1);
    run_op("rem_ovf",   F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_SPEC, 1'b1);
    run_op("divu_big",  F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_NORM, 1'b1);
    run_op("remu_big",  F_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_NORM, 1'b1);
    run_op("div_neg0",  F_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, LAT_SPEC, 1'b1);
    run_op("rem_neg0",  F_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, LAT_SPEC, 1'b1);

    // Back-to-back: second op issued in the cycle right after DONE.
    run_op("b2b_div", F_DIV, 32'd100, 32'd7, 32'd14, LAT_NORM, 1'b1);
    run_op("b2b_mul", F_MUL, 32'd6,   32'd7, 32'd42, LAT_NORM, 1'b1);

    // Asynchronous reset in the middle of ITER, between clock edges.
    @(posedge clk); #1;
    funct3 = F_MUL;
    op_a   = 32'd9;
    op_b   = 32'd9;
    start  = 1'b1;
    for (int j = 1; j <= 15; j++) begin
      @(posedge clk); #1;
    end
    #3;
    rst   = 1'b1;
    start = 1'b0;
    #1;
    check_val("arst_busy", 32'(busy_o), 32'd0);
    check_val("arst_stall", 32'(stall_o), 32'd0);
    check_val("arst_done", 32'(done_o), 32'd0);
    check_val("arst_result", result_o, 32'd0);
    rst = 1'b0;
    run_op("mulh_after_rst", F_MULH, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, LAT_NORM, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
